// File: rtl/audio_dsp_engine.sv
// rtl/audio_dsp_engine.sv - memory-mapped audio MAC engine with program RAM, audio RAM and result bank
module audio_dsp_engine #(
    parameter int PROG_WORDS = 256,
    parameter int CHANS      = 16,
    parameter int SAMPLES    = 32,
    parameter int ACC_W      = 40
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [7:0]  test
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_READ, S_EXEC, S_HALTED} state_t;

    localparam logic [6:0] OP_MAC  = 7'b1000000;
    localparam logic [6:0] OP_MACZ = 7'b1000010;
    localparam logic [6:0] OP_SAVE = 7'b1010000;
    localparam logic [6:0] OP_HALT = 7'b1111111;
    localparam logic signed [ACC_W-1:0] S16_MAX = 32767;
    localparam logic signed [ACC_W-1:0] S16_MIN = -32768;

    logic [31:0] prog_mem  [PROG_WORDS];
    logic [31:0] audio_mem [CHANS*SAMPLES];
    logic [15:0] result_mem [8];

    state_t state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [31:0]      cap_q, cap_d;
    logic             ctrl_q, ctrl_d;
    logic [31:0]      instr_q, instr_d;
    logic [15:0]      sample_q, sample_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [7:0]  region;
    logic        accept, is_wr, dec_prog, dec_ctrl, dec_audio, dec_res, stall;
    logic        prog_we, audio_we, res_we;
    logic [31:0] bmask, prog_wval, audio_wval;
    logic [2:0]  res_idx;
    logic [15:0] res_val;
    logic [6:0]  op;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] save_sh, cap_sh;
    logic        unused_ok;

    assign region    = iomem_addr[31:24];
    assign dec_prog  = region == 8'h60;
    assign dec_ctrl  = region == 8'h62;
    assign dec_audio = region == 8'h64;
    assign dec_res   = region == 8'h66;
    assign accept    = iomem_valid & ~ready_q;
    assign is_wr     = |iomem_wstrb;
    assign bmask     = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign prog_we   = accept & is_wr & dec_prog;
    assign audio_we  = accept & is_wr & dec_audio & ctrl_q;
    // The engine yields RAM access to the bus for the single accept cycle.
    assign stall     = accept & (dec_prog | dec_audio);
    assign prog_wval  = (prog_mem[iomem_addr[9:2]] & ~bmask) | (iomem_wdata & bmask);
    assign audio_wval = (audio_mem[iomem_addr[10:2]] & ~bmask) | (iomem_wdata & bmask);

    assign op      = instr_q[31:25];
    assign prod    = 32'($signed(sample_q)) * 32'($signed(instr_q[15:0]));
    assign save_sh = $signed(acc_q) >>> instr_q[5:0];
    assign cap_sh  = $signed(acc_q) >>> {op[2:0], 2'b00};
    assign unused_ok = ^{iomem_addr[23:11], iomem_addr[1:0], cap_sh[ACC_W-1:32]};

    always_comb begin
        ready_d = accept;
        rdata_d = 32'h0;
        ctrl_d  = ctrl_q;
        if (accept && !is_wr) begin
            if (dec_prog)  rdata_d = prog_mem[iomem_addr[9:2]];
            if (dec_ctrl)  rdata_d = iomem_addr[2] ? cap_q : {31'h0, ctrl_q};
            if (dec_audio) rdata_d = audio_mem[iomem_addr[10:2]];
            if (dec_res)   rdata_d = {{16{result_mem[iomem_addr[4:2]][15]}}, result_mem[iomem_addr[4:2]]};
        end
        if (accept && dec_ctrl && !iomem_addr[2] && iomem_wstrb[0]) ctrl_d = iomem_wdata[0];
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        cap_d    = cap_q;
        instr_d  = instr_q;
        sample_d = sample_q;
        res_we   = 1'b0;
        res_idx  = instr_q[22:20];
        res_val  = save_sh[15:0];
        if (save_sh > S16_MAX)      res_val = 16'h7FFF;
        else if (save_sh < S16_MIN) res_val = 16'h8000;
        if (!stall) begin
            case (state_q)
                S_IDLE: if (!ctrl_q) begin
                    state_d = S_FETCH;
                    pc_d    = 8'h0;
                end
                S_FETCH: begin
                    instr_d = prog_mem[pc_q];
                    state_d = S_READ;
                end
                S_READ: begin
                    sample_d = audio_mem[{instr_q[19:16], instr_q[24:20]}][15:0];
                    state_d  = S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + 8'h1;
                    case (op)
                        OP_MAC:  acc_d = acc_q + {{(ACC_W-32){prod[31]}}, prod};
                        OP_MACZ: acc_d = {{(ACC_W-32){prod[31]}}, prod};
                        OP_SAVE: res_we = 1'b1;
                        OP_HALT: begin
                            state_d = S_HALTED;
                            pc_d    = pc_q;
                        end
                        default: if (op[6:3] == 4'b0010) cap_d = cap_sh[31:0];
                    endcase
                end
                default: state_d = S_HALTED;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= 8'h0;
            acc_q    <= '0;
            cap_q    <= 32'h0;
            ctrl_q   <= 1'b0;
            instr_q  <= 32'h0;
            sample_q <= 16'h0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            cap_q    <= cap_d;
            ctrl_q   <= ctrl_d;
            instr_q  <= instr_d;
            sample_q <= sample_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    // Memories are deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge ck) begin
        if (rst) begin
            if (prog_we)  prog_mem[iomem_addr[9:2]]   <= prog_wval;
            if (audio_we) audio_mem[iomem_addr[10:2]] <= audio_wval;
            if (res_we)   result_mem[res_idx]         <= res_val;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign test        = pc_q;
endmodule

// File: tb/tb_audio_dsp_engine.sv
// tb/tb_audio_dsp_engine.sv - scoreboard bench for audio_dsp_engine
module tb_audio_dsp_engine;
    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic [7:0]  test;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    audio_dsp_engine dut (
        .ck(ck), .rst(rst), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .test(test)
    );

    always #5 ck = ~ck;

    localparam logic [6:0] MAC  = 7'b1000000;
    localparam logic [6:0] MACZ = 7'b1000010;
    localparam logic [6:0] SAVE = 7'b1010000;
    localparam logic [6:0] HALT = 7'b1111111;
    localparam logic [6:0] CAP0 = 7'b0010000;
    localparam logic [6:0] CAP2 = 7'b0010010;

    function automatic logic [31:0] opw(input logic [6:0] o, input logic [4:0] off,
                                        input logic [3:0] ch, input logic [15:0] g);
        return {o, off, ch, g};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        logic ok;
        ok    = 1'b0;
        rdata = 32'h0;
        @(negedge ck);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            @(posedge ck);
            #1;
            if (iomem_ready) begin
                ok    = 1'b1;
                rdata = iomem_rdata;
                break;
            end
        end
        @(negedge ck);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        if (!ok) check("bus_ack_timeout", {31'h0, ok}, 32'h1);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus_xfer(addr, 4'hF, data, dummy);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_xfer(addr, 4'h0, 32'h0, got);
        check(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge ck);
        rst = 1'b0;
        repeat (3) @(posedge ck);
        #1;
        check({tag, "_ready"}, {31'h0, iomem_ready}, 32'h0);
        check({tag, "_test"}, {24'h0, test}, 32'h0);
        @(negedge ck);
        rst = 1'b1;
    endtask

    task automatic wait_halt(input logic [7:0] pc, input string tag);
        int stable;
        logic [7:0] last;
        stable = 0;
        last   = test;
        for (int i = 0; i < 2000 && stable < 8; i++) begin
            @(posedge ck);
            #1;
            if (test == last) stable++;
            else stable = 0;
            last = test;
        end
        check(tag, {24'h0, test}, {24'h0, pc});
    endtask

    function automatic logic [31:0] sat_s16(input longint v);
        if (v > 32767)  return 32'h00007FFF;
        if (v < -32768) return 32'hFFFF8000;
        return 32'(v);
    endfunction

    logic [31:0] rd;
    longint      acc;
    logic [15:0] smp [4];
    logic [15:0] gn  [4];
    logic [5:0]  sh;

    initial begin
        // Reset state and RAM retention
        repeat (3) @(posedge ck);
        #1;
        check("rst_ready", {31'h0, iomem_ready}, 32'h0);
        check("rst_test", {24'h0, test}, 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        @(negedge ck);
        rst = 1'b1;
        bus_write(32'h6000_0028, 32'hDEAD_BEEF);
        pulse_reset("rst2");
        bus_read(32'h6000_0028, 32'hDEAD_BEEF, "prog_retained");

        // Bus behaviour
        bus_write(32'h6000_0000, 32'h8411_2000);
        bus_xfer(32'h6000_0000, 4'h0, 32'h0, rd);
        check("prog_rdback", rd, 32'h8411_2000);
        @(posedge ck);
        #1;
        check("ready_pulse", {31'h0, iomem_ready}, 32'h0);
        bus_write(32'h6200_0000, 32'h1);
        bus_read(32'h6200_0000, 32'h1, "ctrl_rdback");
        bus_write(32'h6400_0014, 32'h1122_3344);
        bus_xfer(32'h6400_0014, 4'b0011, 32'hAAAA_BBBB, rd);
        bus_read(32'h6400_0014, 32'h1122_BBBB, "audio_bytes");
        bus_write(32'h6200_0000, 32'h0);
        bus_write(32'h6400_0014, 32'h5555_6666);
        bus_read(32'h6400_0014, 32'h1122_BBBB, "audio_locked");
        bus_write(32'h7000_0000, 32'hFFFF_FFFF);
        bus_read(32'h7000_0000, 32'h0, "undecoded");

        // CAPTURE after a single MAC-Z
        bus_write(32'h6200_0000, 32'h1);
        bus_write(32'h6400_0000 + 36*4, 32'h1111);
        bus_write(32'h6400_0000 + 37*4, 32'h1234);
        bus_write(32'h6400_0000 + 38*4, 32'hABCD);
        bus_write(32'h6400_0000 + 39*4, 32'h2222);
        bus_write(32'h6000_0000, opw(MACZ, 4, 1, 16'h2000));
        bus_write(32'h6000_0004, opw(CAP0, 0, 0, 16'h0));
        bus_write(32'h6000_0008, opw(HALT, 0, 0, 16'h0));
        pulse_reset("runA");
        wait_halt(8'd2, "halt_pc_A");
        bus_read(32'h6200_0004, 32'h0222_2000, "cap_macz");

        // MAC chain, scaled save and negative saturation
        bus_write(32'h6200_0000, 32'h1);
        bus_write(32'h6000_0004, opw(MAC, 5, 1, 16'h89AB));
        bus_write(32'h6000_0008, opw(MAC, 6, 1, 16'h1234));
        bus_write(32'h6000_000C, opw(MAC, 7, 1, 16'h1111));
        bus_write(32'h6000_0010, opw(CAP0, 0, 0, 16'h0));
        bus_write(32'h6000_0014, opw(SAVE, 0, 0, 16'd16));
        bus_write(32'h6000_0018, opw(SAVE, 1, 0, 16'd0));
        bus_write(32'h6000_001C, opw(CAP2, 0, 0, 16'h0));
        bus_write(32'h6000_0020, opw(HALT, 0, 0, 16'h0));
        pulse_reset("runB");
        wait_halt(8'd8, "halt_pc_B");
        bus_read(32'h6200_0004, 32'hFFF6_01F2, "cap_acc_hi");
        bus_read(32'h6600_0000, 32'hFFFF_F601, "save_shift16");
        bus_read(32'h6600_0004, 32'hFFFF_8000, "save_sat_neg");
        bus_read(32'h6200_0000, 32'h0, "ctrl_after_rst");

        // Positive saturation plus a randomised MAC/SAVE against the model
        bus_write(32'h6200_0000, 32'h1);
        bus_write(32'h6400_0000 + 64*4, 32'h7FFF);
        acc = 0;
        sh = 6'($urandom_range(0, 20));
        for (int i = 0; i < 4; i++) begin
            smp[i] = 16'($urandom);
            gn[i]  = 16'($urandom);
            bus_write(32'h6400_0000 + (96 + i) * 4, {16'h0, smp[i]});
            acc += longint'($signed(smp[i])) * longint'($signed(gn[i]));
        end
        bus_write(32'h6000_0000, opw(MACZ, 0, 2, 16'h7FFF));
        bus_write(32'h6000_0004, opw(MAC, 0, 2, 16'h7FFF));
        bus_write(32'h6000_0008, opw(SAVE, 2, 0, 16'd0));
        bus_write(32'h6000_000C, opw(MACZ, 0, 3, gn[0]));
        bus_write(32'h6000_0010, opw(MAC, 1, 3, gn[1]));
        bus_write(32'h6000_0014, opw(MAC, 2, 3, gn[2]));
        bus_write(32'h6000_0018, opw(MAC, 3, 3, gn[3]));
        bus_write(32'h6000_001C, opw(SAVE, 3, 0, {10'h0, sh}));
        bus_write(32'h6000_0020, opw(HALT, 0, 0, 16'h0));
        pulse_reset("runC");
        wait_halt(8'd8, "halt_pc_C");
        bus_read(32'h6600_0008, 32'h0000_7FFF, "save_sat_pos");
        bus_read(32'h6600_000C, sat_s16(acc >>> sh), "save_random");
        bus_read(32'h6600_0000, 32'hFFFF_F601, "result_kept");

        // Reset mid-run restarts from pc 0
        bus_write(32'h6200_0000, 32'h1);
        for (int i = 0; i < 20; i++) bus_write(32'h6000_0000 + i * 4, 32'h0);
        bus_write(32'h6000_0000 + 20 * 4, opw(HALT, 0, 0, 16'h0));
        pulse_reset("runD");
        repeat (15) @(posedge ck);
        #1;
        check("midrun_moving", {31'h0, test > 8'd2 && test < 8'd20}, 32'h1);
        pulse_reset("midrun");
        wait_halt(8'd20, "halt_pc_D");
        repeat (10) @(posedge ck);
        #1;
        check("halt_stays", {24'h0, test}, 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
